// File: rtl/pd_math_pipe_if.sv
// -----------------------------------------------------------------------------
// pd_math_pipe_if
//   Bundles the error-sample input and the P/D result outputs of pd_math_pipe.
//
//   Signals
//     err_vld  1   err_sat holds a new sample this cycle
//     err_sat  10  signed saturated error, -512..511
//     P_term   14  signed proportional term
//     D_term   13  signed derivative term
//     PD_sum   15  signed P_term + D_term
//     pd_vld   1   one-cycle strobe, P_term/D_term/PD_sum valid
//     primed   1   history queue is full
//
//   Modports
//     master : error producer / result consumer
//     slave  : pd_math_pipe itself
// -----------------------------------------------------------------------------
interface pd_math_pipe_if;
   logic               err_vld;
   logic signed [9:0]  err_sat;
   logic signed [13:0] P_term;
   logic signed [12:0] D_term;
   logic signed [14:0] PD_sum;
   logic               pd_vld;
   logic               primed;

   modport master (
      output err_vld, err_sat,
      input  P_term, D_term, PD_sum, pd_vld, primed
   );

   modport slave (
      input  err_vld, err_sat,
      output P_term, D_term, PD_sum, pd_vld, primed
   );
endinterface

// File: rtl/pd_math_pipe.sv
// -----------------------------------------------------------------------------
// pd_math_pipe
//   Consumes the 10-bit saturated error and produces the proportional and
//   derivative terms plus their sum through a 3-stage pipeline.
//   D_diff is taken against the sample D_QUEUE_DEPTH valid samples back, held
//   in a shift-register history queue that only advances on err_vld.
//
//   Ports
//     clk   in  system clock, all state on the rising edge
//     rst   in  synchronous reset, active-high
//     bus   pd_math_pipe_if.slave (err_vld/err_sat in; P_term, D_term,
//           PD_sum, pd_vld, primed out)
//
//   Parameters
//     D_QUEUE_DEPTH  samples between current and previous error (2..31)
//     P_COEFF        proportional gain 0..15, treated as 5-bit signed
//     D_COEFF        derivative gain 0..63, treated as 7-bit signed
//
//   Build option
//     PD_SUM_SAT_EN  when defined, PD_sum is clamped to -8192..8191 and driven
//                    sign-extended on the 15-bit port; otherwise it is the
//                    full 15-bit sum, which cannot overflow.
// -----------------------------------------------------------------------------
module pd_math_pipe #(
   parameter int         D_QUEUE_DEPTH = 12,
   parameter logic [4:0] P_COEFF       = 5'h08,
   parameter logic [5:0] D_COEFF       = 6'h07
) (
   input logic           clk,
   input logic           rst,
   pd_math_pipe_if.slave bus
);

   localparam int               CNT_W    = $clog2(D_QUEUE_DEPTH + 1);
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(D_QUEUE_DEPTH);

   // Gains widened to product width; the zero MSB keeps them positive.
   localparam logic signed [13:0] P_GAIN = 14'($signed(P_COEFF));
   localparam logic signed [12:0] D_GAIN = 13'($signed({1'b0, D_COEFF}));

   // History queue and priming
   logic signed [9:0]  queue_q [D_QUEUE_DEPTH];
   logic signed [9:0]  queue_d [D_QUEUE_DEPTH];
   logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic               primed_q, primed_d;

   // Stage 1
   logic               v1_q, v1_d;
   logic signed [9:0]  err_q, err_d;
   logic signed [10:0] d_diff_q, d_diff_d;
   logic               prm_q, prm_d;

   // Stage 2
   logic               v2_q, v2_d;
   logic signed [13:0] p_s2_q, p_s2_d;
   logic signed [12:0] d_s2_q, d_s2_d;
   logic signed [6:0]  d_sat_s;

   // Stage 3 / outputs
   logic               pd_vld_q, pd_vld_d;
   logic signed [13:0] P_term_q, P_term_d;
   logic signed [12:0] D_term_q, D_term_d;
   logic signed [14:0] PD_sum_q, PD_sum_d;
   logic signed [14:0] sum_full_s;

   // History queue shift and fill counter, both advancing only on a valid sample
   always_comb begin
      queue_d    = queue_q;
      fill_cnt_d = fill_cnt_q;
      if (bus.err_vld) begin
         queue_d[0] = bus.err_sat;
         for (int i = 1; i < D_QUEUE_DEPTH; i++) begin
            queue_d[i] = queue_q[i-1];
         end
         if (fill_cnt_q != FILL_MAX) begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
         end else begin
            fill_cnt_d = fill_cnt_q;
         end
      end else begin
         queue_d    = queue_q;
         fill_cnt_d = fill_cnt_q;
      end
      primed_d = (fill_cnt_d == FILL_MAX);
   end

   // Stage 1: capture sample, difference against the oldest entry, priming flag
   always_comb begin
      v1_d     = bus.err_vld;
      err_d    = err_q;
      d_diff_d = d_diff_q;
      prm_d    = prm_q;
      if (bus.err_vld) begin
         err_d    = bus.err_sat;
         // 11 bits hold any 10-bit difference without overflow
         d_diff_d = 11'(bus.err_sat) - 11'(queue_q[D_QUEUE_DEPTH-1]);
         // priming state before this sample enters
         prm_d    = primed_q;
      end else begin
         err_d    = err_q;
         d_diff_d = d_diff_q;
         prm_d    = prm_q;
      end
   end

   // Stage 2: saturate the difference to 7 bits and apply the gains
   always_comb begin
      v2_d   = v1_q;
      p_s2_d = p_s2_q;
      d_s2_d = d_s2_q;
      if (d_diff_q > 11'sd63) begin
         d_sat_s = 7'sd63;
      end else if (d_diff_q < -11'sd64) begin
         d_sat_s = -7'sd64;
      end else begin
         d_sat_s = d_diff_q[6:0];
      end
      if (v1_q) begin
         p_s2_d = 14'(err_q) * P_GAIN;
         if (prm_q) begin
            d_s2_d = 13'(d_sat_s) * D_GAIN;
         end else begin
            d_s2_d = 13'sd0;
         end
      end else begin
         p_s2_d = p_s2_q;
         d_s2_d = d_s2_q;
      end
   end

   // Stage 3: sum and output registers, which hold between strobes
   always_comb begin
      pd_vld_d   = v2_q;
      P_term_d   = P_term_q;
      D_term_d   = D_term_q;
      PD_sum_d   = PD_sum_q;
      sum_full_s = 15'(p_s2_q) + 15'(d_s2_q);
      if (v2_q) begin
         P_term_d = p_s2_q;
         D_term_d = d_s2_q;
`ifdef PD_SUM_SAT_EN
         if (sum_full_s > 15'sd8191) begin
            PD_sum_d = 15'sd8191;
         end else if (sum_full_s < -15'sd8192) begin
            PD_sum_d = -15'sd8192;
         end else begin
            PD_sum_d = sum_full_s;
         end
`else
         PD_sum_d = sum_full_s;
`endif
      end else begin
         P_term_d = P_term_q;
         D_term_d = D_term_q;
         PD_sum_d = PD_sum_q;
      end
   end

   // State registers with synchronous reset; reset discards in-flight samples
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
            queue_q[i] <= 10'sd0;
         end
         fill_cnt_q <= '0;
         primed_q   <= 1'b0;
         v1_q       <= 1'b0;
         err_q      <= 10'sd0;
         d_diff_q   <= 11'sd0;
         prm_q      <= 1'b0;
         v2_q       <= 1'b0;
         p_s2_q     <= 14'sd0;
         d_s2_q     <= 13'sd0;
         pd_vld_q   <= 1'b0;
         P_term_q   <= 14'sd0;
         D_term_q   <= 13'sd0;
         PD_sum_q   <= 15'sd0;
      end else begin
         for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
            queue_q[i] <= queue_d[i];
         end
         fill_cnt_q <= fill_cnt_d;
         primed_q   <= primed_d;
         v1_q       <= v1_d;
         err_q      <= err_d;
         d_diff_q   <= d_diff_d;
         prm_q      <= prm_d;
         v2_q       <= v2_d;
         p_s2_q     <= p_s2_d;
         d_s2_q     <= d_s2_d;
         pd_vld_q   <= pd_vld_d;
         P_term_q   <= P_term_d;
         D_term_q   <= D_term_d;
         PD_sum_q   <= PD_sum_d;
      end
   end

   assign bus.P_term = P_term_q;
   assign bus.D_term = D_term_q;
   assign bus.PD_sum = PD_sum_q;
   assign bus.pd_vld = pd_vld_q;
   assign bus.primed = primed_q;

endmodule
